// File: rtl/frankie_io_pkg.sv
// ============================================================================
// Module   : frankie_io_pkg
// Brief    : Shared constants and helpers for the frankie I/O hub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frankie_io_pkg;

    // Status word bit positions
    localparam int ST_NONEMPTY = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OUTPEND  = 2;
    localparam int ST_UNDER    = 3;
    localparam int ST_OVER     = 4;

    // io_addr field layout
    localparam int ADDR_W       = 4;
    localparam int ADDR_SEL_BIT = 3;
    localparam int ADDR_CH_MSB  = 2;
    localparam int ADDR_CH_LSB  = 0;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/frankie_io_fifo.sv
// ============================================================================
// Module   : frankie_io_fifo
// Brief    : Single-clock input FIFO with registered storage, pointers, count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frankie_io_fifo
    import frankie_io_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/frankie_io_hub.sv
// ============================================================================
// Module   : frankie_io_hub
// Brief    : Multi-channel I/O hub: input FIFOs, output holding registers,
//            sticky error flags and a registered processor read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frankie_io_hub
    import frankie_io_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         io_addr,
    input  logic                      io_rd,
    input  logic                      io_wr,
    input  logic [WIDTH-1:0]          io_wdata,
    output logic [WIDTH-1:0]          io_rdata,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready
);

    logic [2:0]          w_ch_idx;
    logic                w_is_status;
    logic                w_ch_ok;

    logic [WIDTH-1:0]    w_head [CHANNELS];
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_under_set;
    logic [CHANNELS-1:0] w_over_set;
    logic [CHANNELS-1:0] w_stat_clr;
    logic [CHANNELS-1:0] w_load;

    logic [WIDTH-1:0]    r_out_data [CHANNELS];
    logic [CHANNELS-1:0] r_out_valid;
    logic [CHANNELS-1:0] r_under;
    logic [CHANNELS-1:0] r_over;
    logic [WIDTH-1:0]    r_io_rdata;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_ch_idx    = io_addr[ADDR_CH_MSB:ADDR_CH_LSB];
    assign w_is_status = io_addr[ADDR_SEL_BIT];
    assign w_ch_ok     = ({1'b0, w_ch_idx} < 4'(CHANNELS));

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic w_hit;
            logic w_rd_data_hit;
            logic w_wr_hit;

            assign w_hit         = w_ch_ok && (w_ch_idx == 3'(c));
            assign w_rd_data_hit = io_rd & ~w_is_status & w_hit;
            assign w_wr_hit      = io_wr & ~w_is_status & w_hit;

            assign w_pop[c]       = w_rd_data_hit & ~w_empty[c];
            assign w_under_set[c] = w_rd_data_hit & w_empty[c];
            assign w_stat_clr[c]  = io_rd & w_is_status & w_hit;
            // A write is accepted if the register is free or draining this cycle
            assign w_load[c]      = w_wr_hit & (~r_out_valid[c] | out_ready[c]);
            assign w_over_set[c]  = w_wr_hit & r_out_valid[c] & ~out_ready[c];

            assign in_ready[c] = ~reset & ~w_full[c];
            assign w_push[c]   = in_valid[c] & in_ready[c];
            assign out_data[c*WIDTH +: WIDTH] = r_out_data[c];

            frankie_io_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (w_push[c]),
                .push_data (in_data[c*WIDTH +: WIDTH]),
                .pop       (w_pop[c]),
                .full      (w_full[c]),
                .empty     (w_empty[c]),
                .head      (w_head[c])
            );
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign io_rdata  = r_io_rdata;

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_ch_ok && (w_ch_idx == 3'(i))) begin
                if (w_is_status) begin
                    w_rd_word[ST_NONEMPTY] = ~w_empty[i];
                    w_rd_word[ST_FULL]     = w_full[i];
                    w_rd_word[ST_OUTPEND]  = r_out_valid[i];
                    w_rd_word[ST_UNDER]    = r_under[i];
                    w_rd_word[ST_OVER]     = r_over[i];
                end else if (!w_empty[i]) begin
                    w_rd_word = w_head[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_io_rdata  <= '0;
            r_out_valid <= '0;
            r_under     <= '0;
            r_over      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_out_data[i] <= '0;
            end
        end else begin
            if (io_rd) begin
                r_io_rdata <= w_rd_word;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load[i]) begin
                    r_out_valid[i] <= 1'b1;
                    r_out_data[i]  <= io_wdata;
                end else if (out_ready[i]) begin
                    r_out_valid[i] <= 1'b0;
                end
                // Set takes priority over a status-read clear
                if (w_under_set[i])     r_under[i] <= 1'b1;
                else if (w_stat_clr[i]) r_under[i] <= 1'b0;
                if (w_over_set[i])      r_over[i]  <= 1'b1;
                else if (w_stat_clr[i]) r_over[i]  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/frankie_io_hub.md
# frankie_io_hub

Parametrised multi-channel I/O hub replacing Frankie's single fixed 16-bit `io_in`/`io_out` pair. It sits between the processor datapath's I/O strobes and CHANNELS external ports. Each channel has a buffered input FIFO with a valid/ready handshake and a one-entry output holding register. Sticky error flags are readable through a per-channel status word.

## Interface
Parameters:
- WIDTH, 16, data width of every channel and of the processor data bus
- CHANNELS, 2, number of independent I/O channels (1..8)
- FIFO_DEPTH, 4, input FIFO entries per channel (power of two, ≥2)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- io_addr  in  4  [3] 0=data / 1=status; [2:0] channel index
- io_rd  in  1  one-cycle read strobe from processor
- io_wr  in  1  one-cycle write strobe from processor
- io_wdata  in  WIDTH  processor write data
- io_rdata  out  WIDTH  registered read data
- in_data  in  CHANNELS*WIDTH  external input words, channel c at [c*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  external word offered
- in_ready  out  CHANNELS  hub accepts word
- out_data  out  CHANNELS*WIDTH  external output words
- out_valid  out  CHANNELS  output word pending
- out_ready  in  CHANNELS  external sink accepts word

## Operation
- Input push: for channel c, a word is accepted when `in_valid[c] & in_ready[c]`. `in_ready[c] = !full[c]`; it is 0 while reset is high.
- Data read (`io_rd`, addr[3]=0): pops the head of channel c into io_rdata. If the FIFO is empty, io_rdata gets 0, no pop occurs, and sticky UNDERFLOW[c] is set.
- Status read (`io_rd`, addr[3]=1): io_rdata = {zeros, OVERFLOW, UNDERFLOW, out_valid, full, !empty} in bits [4:0]. This read clears both sticky bits of that channel. A set event in the same cycle wins over the clear.
- Data write (`io_wr`, addr[3]=0):
  - If out_valid[c]=0, or the external transfer completes in the same cycle, the word loads into out_data[c] and out_valid[c] is set.
  - Otherwise the word is dropped and sticky OVERFLOW[c] is set.
- Status write: ignored.
- Output transfer: `out_valid[c] & out_ready[c]` clears out_valid[c] unless a simultaneous load occurs. out_data holds its value after the transfer.
- Channel index ≥ CHANNELS: reads return 0, writes are dropped, no flag changes.
- io_rd and io_wr in the same cycle are independent and both take effect.
- Push and pop on the same channel in the same cycle:
  - Non-empty FIFO: both occur and the count is unchanged.
  - Empty FIFO: the pop underflows and the push is stored.
  - Full FIFO: no push is possible, since in_ready=0.
- Ordering: strict FIFO per channel; pointers wrap modulo FIFO_DEPTH; count has range 0..FIFO_DEPTH.

## Timing
- Reset values:
  - io_rdata=0
  - all FIFOs empty
  - out_valid=0, out_data=0
  - sticky flags=0
  - in_ready=0 during reset, then all 1 in the first cycle after reset
- Read latency: 1 cycle. io_rdata is updated on the clock edge that samples io_rd and holds until the next io_rd.
- Push latency: a word accepted at edge N is poppable by an io_rd sampled at edge N+1. `!empty` reflects it from edge N.
- in_ready deasserts in the cycle after the push that fills the FIFO.
- Write-to-out_valid: 1 cycle.
- Reset asserted mid-transfer: all state is discarded on the next edge, with no partial handshakes.

## Structure
- Package `frankie_io_pkg`:
  - status bit index constants (ST_NONEMPTY=0, ST_FULL=1, ST_OUTPEND=2, ST_UNDER=3, ST_OVER=4)
  - address field positions
  - `clog2`-based pointer-width helper
- Sub-module `frankie_io_fifo` (WIDTH, DEPTH), instantiated once per channel via generate:
  - inputs push/pop, outputs full/empty/head
  - registered storage, pointer and count
- Output registers, sticky flags and the read mux live in the top.

## Test plan
- Reset, then push 0x1111, 0x2222 on ch0, then io_rd ch0 twice → io_rdata = 0x1111, then 0x2222 (one cycle after each strobe); status ch0 = 0x00.
- Push 4 words to ch1 with in_valid held high → in_ready[1] drops after the 4th; a 5th word is held off; one pop brings in_ready[1] back to 1 and the 5th word is accepted.
- io_rd ch0 on empty → io_rdata=0; status read = 0x08; second status read = 0x00.
- io_wr 0xBEEF to ch1 with out_ready=0, then io_wr 0xCAFE → out_data stays 0xBEEF; status = 0x14. With out_ready=1 plus io_wr 0x1234 in the same cycle → out_valid stays 1 and out_data=0x1234, no overflow.
- Simultaneous push 0xAAAA and pop on a 1-entry ch0 → pop returns the old head, count stays 1, next pop returns 0xAAAA.
- Assert reset with 3 words queued and out_valid=1 → the next cycle has all FIFOs empty, out_valid=0, io_rdata=0, in_ready=0, then in_ready all 1.
